// File: rtl/clkdiv_pkg.sv
// Shared definitions for the clock-divider status blocks.
// Contents:
//   state_e          - measurement FSM encoding (IDLE / MEASURE / TIMEOUT)
//   DEF_*            - default parameters for the 50 MHz board (1 Hz nominal input)
//   in_window()      - inclusive range test used for the lock decision
package clkdiv_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MEAS = 2'd1,
        ST_TMO  = 2'd2
    } state_e;

    localparam int unsigned DEF_CNT_W       = 32'd32;
    localparam int unsigned DEF_EXP_PERIOD  = 32'd50_000_000;
    localparam int unsigned DEF_TOL         = 32'd500;
    localparam int unsigned DEF_TIMEOUT_CYC = 32'd100_000_000;

    // True when lo <= val <= hi; arguments are widened by the caller so one
    // helper serves every counter width.
    function automatic logic in_window(input logic [63:0] val,
                                       input logic [63:0] lo,
                                       input logic [63:0] hi);
        return (val >= lo) && (val <= hi);
    endfunction

endpackage

// File: rtl/sync_edge_det.sv
// Two-flop synchronizer followed by a delay flop, giving a clean level and
// single-cycle edge strobes for an input asynchronous to clk.
// Ports:
//   clk   in  system clock
//   rst   in  asynchronous active-high reset
//   d_in  in  asynchronous input
//   lvl   out synchronized level (second sync stage)
//   rise  out one-cycle strobe on a 0->1 transition of lvl
//   fall  out one-cycle strobe on a 1->0 transition of lvl
module sync_edge_det (
    input  logic clk,
    input  logic rst,
    input  logic d_in,
    output logic lvl,
    output logic rise,
    output logic fall
);

    logic s1_q, s2_q, s3_q;
    logic s1_d, s2_d, s3_d;

    // Next values of the shift chain: sync stage 1, sync stage 2, delay stage.
    always_comb begin
        s1_d = d_in;
        s2_d = s1_q;
        s3_d = s2_q;
    end

    // Synchronizer and delay registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_q <= 1'b0;
            s2_q <= 1'b0;
            s3_q <= 1'b0;
        end else begin
            s1_q <= s1_d;
            s2_q <= s2_d;
            s3_q <= s3_d;
        end
    end

    assign lvl  = s2_q;
    assign rise = s2_q & ~s3_q;
    assign fall = ~s2_q & s3_q;

endmodule

// File: rtl/clock_period_meter.sv
// Measures a slow clock (sig_in) against the system clock clki: reports the
// last full period and its high time in clki cycles, a lock flag for
// period within EXP_PERIOD +/- TOL, and a sticky loss flag when no rising
// edge arrives for TIMEOUT_CYC cycles.
// Ports:
//   clki       in   system clock
//   rst        in   asynchronous active-high reset
//   sig_in     in   measured clock, asynchronous to clki
//   period     out  last complete period (rise to rise), clki cycles
//   high_time  out  cycles sig_in was high within that period
//   meas_valid out  one-cycle pulse when period/high_time update
//   locked     out  last period in tolerance and no timeout since
//   lost       out  timeout seen; cleared by the next rising edge
module clock_period_meter
    import clkdiv_pkg::*;
#(
    parameter int unsigned CNT_W       = DEF_CNT_W,
    parameter int unsigned EXP_PERIOD  = DEF_EXP_PERIOD,
    parameter int unsigned TOL         = DEF_TOL,
    parameter int unsigned TIMEOUT_CYC = DEF_TIMEOUT_CYC
) (
    input  logic             clki,
    input  logic             rst,
    input  logic             sig_in,
    output logic [CNT_W-1:0] period,
    output logic [CNT_W-1:0] high_time,
    output logic             meas_valid,
    output logic             locked,
    output logic             lost
);

    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] TMO_LIM  = CNT_W'(TIMEOUT_CYC);
    localparam logic [63:0]      LIM_LO   = 64'(EXP_PERIOD) - 64'(TOL);
    localparam logic [63:0]      LIM_HI   = 64'(EXP_PERIOD) + 64'(TOL);

    logic lvl_s, rise_s, unused_fall_s;

    sync_edge_det u_sync (
        .clk  (clki),
        .rst  (rst),
        .d_in (sig_in),
        .lvl  (lvl_s),
        .rise (rise_s),
        .fall (unused_fall_s)
    );

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_p_q, cnt_p_d;
    logic [CNT_W-1:0] cnt_h_q, cnt_h_d;
    logic [CNT_W-1:0] period_q, period_d;
    logic [CNT_W-1:0] high_time_q, high_time_d;
    logic             meas_valid_q, meas_valid_d;
    logic             locked_q, locked_d;
    logic             lost_q, lost_d;

    logic [CNT_W-1:0] cnt_p_inc_s, cnt_h_inc_s;
    logic             tmo_hit_s;

    // Saturating increments and the timeout compare.
    always_comb begin
        cnt_p_inc_s = (cnt_p_q == CNT_MAX) ? cnt_p_q : cnt_p_q + CNT_ONE;
        cnt_h_inc_s = (cnt_h_q == CNT_MAX) ? cnt_h_q : cnt_h_q + CNT_ONE;
        tmo_hit_s   = (cnt_p_q == TMO_LIM);
    end

    // FSM next state, counters and output register next values.
    // A rise is tested before the timeout so an edge landing exactly on
    // TIMEOUT_CYC still produces a measurement.
    always_comb begin
        state_d      = state_q;
        cnt_p_d      = cnt_p_inc_s;
        cnt_h_d      = cnt_h_q;
        period_d     = period_q;
        high_time_d  = high_time_q;
        meas_valid_d = 1'b0;
        locked_d     = locked_q;
        lost_d       = lost_q;

        case (state_q)
            ST_IDLE: begin
                if (rise_s) begin
                    cnt_p_d = CNT_ONE;
                    cnt_h_d = CNT_ONE;
                    state_d = ST_MEAS;
                end else if (tmo_hit_s) begin
                    state_d  = ST_TMO;
                    lost_d   = 1'b1;
                    locked_d = 1'b0;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_MEAS: begin
                if (lvl_s) begin
                    cnt_h_d = cnt_h_inc_s;
                end else begin
                    cnt_h_d = cnt_h_q;
                end
                if (rise_s) begin
                    period_d     = cnt_p_q;
                    high_time_d  = cnt_h_q;
                    meas_valid_d = 1'b1;
                    locked_d     = in_window(64'(cnt_p_q), LIM_LO, LIM_HI);
                    lost_d       = 1'b0;
                    cnt_p_d      = CNT_ONE;
                    cnt_h_d      = CNT_ONE;
                end else if (tmo_hit_s) begin
                    state_d  = ST_TMO;
                    lost_d   = 1'b1;
                    locked_d = 1'b0;
                end else begin
                    state_d = ST_MEAS;
                end
            end
            ST_TMO: begin
                // Restart on the edge; the period it opens is measured normally,
                // the stretch that timed out is thrown away.
                if (rise_s) begin
                    cnt_p_d = CNT_ONE;
                    cnt_h_d = CNT_ONE;
                    lost_d  = 1'b0;
                    state_d = ST_MEAS;
                end else begin
                    state_d = ST_TMO;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_p_d = CNT_ZERO;
                cnt_h_d = CNT_ZERO;
            end
        endcase
    end

    // State, counter and output registers.
    always_ff @(posedge clki or posedge rst) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            cnt_p_q      <= CNT_ZERO;
            cnt_h_q      <= CNT_ZERO;
            period_q     <= CNT_ZERO;
            high_time_q  <= CNT_ZERO;
            meas_valid_q <= 1'b0;
            locked_q     <= 1'b0;
            lost_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_p_q      <= cnt_p_d;
            cnt_h_q      <= cnt_h_d;
            period_q     <= period_d;
            high_time_q  <= high_time_d;
            meas_valid_q <= meas_valid_d;
            locked_q     <= locked_d;
            lost_q       <= lost_d;
        end
    end

    assign period     = period_q;
    assign high_time  = high_time_q;
    assign meas_valid = meas_valid_q;
    assign locked     = locked_q;
    assign lost       = lost_q;

endmodule

// File: tb/tb_clock_period_meter.sv
// Self-checking bench for clock_period_meter (CNT_W=16, EXP_PERIOD=20,
// TOL=1, TIMEOUT_CYC=100). sig_in is driven on falling clki edges; every
// completed period that should be reported is pushed to a scoreboard when
// the closing rise is driven and popped when meas_valid is seen.
module tb_clock_period_meter;

    localparam int CNT_W = 16;
    localparam int EXP   = 20;
    localparam int TOL   = 1;
    localparam int TMO   = 100;

    logic             clki = 1'b0;
    logic             rst;
    logic             sig_in = 1'b0;
    logic [CNT_W-1:0] period;
    logic [CNT_W-1:0] high_time;
    logic             meas_valid;
    logic             locked;
    logic             lost;

    typedef struct packed {
        logic [15:0] period;
        logic [15:0] high;
        logic        locked;
        logic        lost;
    } meas_t;

    meas_t sb_q[$];
    int    checks   = 0;
    int    errors   = 0;
    bit    armed    = 1'b0;
    int    prev_per = 0;
    int    prev_hi  = 0;

    clock_period_meter #(
        .CNT_W       (32'd16),
        .EXP_PERIOD  (32'd20),
        .TOL         (32'd1),
        .TIMEOUT_CYC (32'd100)
    ) dut (
        .clki       (clki),
        .rst        (rst),
        .sig_in     (sig_in),
        .period     (period),
        .high_time  (high_time),
        .meas_valid (meas_valid),
        .locked     (locked),
        .lost       (lost)
    );

    always #10 clki = ~clki;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        if (obs !== expv) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, expv);
        end
    endtask

    // Model of a driven rising edge: it closes the previous period, which is
    // reported unless it is the first since reset/timeout or it timed out.
    task automatic rise_edge();
        meas_t m;
        if (armed && prev_per <= TMO) begin
            m.period = 16'(prev_per);
            m.high   = 16'(prev_hi);
            m.locked = (prev_per >= EXP - TOL) && (prev_per <= EXP + TOL);
            m.lost   = 1'b0;
            sb_q.push_back(m);
        end
        armed = 1'b1;
    endtask

    task automatic drive_period(input int hi, input int lo);
        rise_edge();
        sig_in = 1'b1;
        repeat (hi) @(negedge clki);
        sig_in = 1'b0;
        repeat (lo) @(negedge clki);
        prev_per = hi + lo;
        prev_hi  = hi;
    endtask

    // Scoreboard consumer.
    always @(negedge clki) begin : monitor
        meas_t m;
        if (rst === 1'b0 && meas_valid === 1'b1) begin
            if (sb_q.size() == 0) begin
                check_eq("spurious_mv", 32'(meas_valid), 32'd0);
            end else begin
                m = sb_q.pop_front();
                check_eq("mv_period", 32'(period), 32'(m.period));
                check_eq("mv_high",   32'(high_time), 32'(m.high));
                check_eq("mv_locked", 32'(locked), 32'(m.locked));
                check_eq("mv_lost",   32'(lost), 32'(m.lost));
            end
        end
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // 1. reset, then idle with sig_in low until timeout
        rst = 1'b0;
        #1 rst = 1'b1;
        repeat (5) @(negedge clki);
        check_eq("rst_period", 32'(period), 32'd0);
        check_eq("rst_high",   32'(high_time), 32'd0);
        check_eq("rst_mv",     32'(meas_valid), 32'd0);
        check_eq("rst_locked", 32'(locked), 32'd0);
        check_eq("rst_lost",   32'(lost), 32'd0);
        rst = 1'b0;
        repeat (100) @(negedge clki);
        check_eq("idle_lost_early", 32'(lost), 32'd0);
        @(negedge clki);
        check_eq("idle_lost",   32'(lost), 32'd1);
        check_eq("idle_locked", 32'(locked), 32'd0);

        // 2. nominal 10/10 wave
        repeat (4) drive_period(10, 10);
        check_eq("nom_locked", 32'(locked), 32'd1);
        check_eq("nom_lost",   32'(lost), 32'd0);

        // 3. tolerance boundaries: 22, 21, 19, 18; then 8/12 duty
        repeat (2) drive_period(11, 11);
        repeat (2) drive_period(11, 10);
        repeat (2) drive_period(10, 9);
        repeat (2) drive_period(9, 9);
        repeat (2) drive_period(8, 12);
        repeat (2) drive_period(10, 10);

        // 5. one-cycle reset during the low phase while locked
        rise_edge();
        sig_in = 1'b1;
        repeat (10) @(negedge clki);
        sig_in = 1'b0;
        repeat (5) @(negedge clki);
        check_eq("pre_rst_locked", 32'(locked), 32'd1);
        rst = 1'b1;
        #1;
        check_eq("mid_rst_period", 32'(period), 32'd0);
        check_eq("mid_rst_high",   32'(high_time), 32'd0);
        check_eq("mid_rst_locked", 32'(locked), 32'd0);
        check_eq("mid_rst_lost",   32'(lost), 32'd0);
        @(negedge clki);
        rst   = 1'b0;
        armed = 1'b0;
        repeat (5) @(negedge clki);
        repeat (3) drive_period(10, 10);

        // 4. locked, then sig_in held low until timeout
        rise_edge();
        sig_in = 1'b1;
        repeat (10) @(negedge clki);
        sig_in = 1'b0;
        repeat (92) @(negedge clki);
        check_eq("hold_lost_early",   32'(lost), 32'd0);
        check_eq("hold_locked_early", 32'(locked), 32'd1);
        @(negedge clki);
        check_eq("hold_lost",   32'(lost), 32'd1);
        check_eq("hold_locked", 32'(locked), 32'd0);
        check_eq("hold_period", 32'(period), 32'd20);
        repeat (20) @(negedge clki);
        prev_per = 999;
        prev_hi  = 10;
        // restart: lost clears in the cycle after the detected rise
        rise_edge();
        sig_in = 1'b1;
        repeat (2) @(negedge clki);
        check_eq("restart_lost_hold", 32'(lost), 32'd1);
        @(negedge clki);
        check_eq("restart_lost_clr", 32'(lost), 32'd0);
        check_eq("restart_locked",   32'(locked), 32'd0);
        repeat (7) @(negedge clki);
        sig_in = 1'b0;
        repeat (10) @(negedge clki);
        prev_per = 20;
        prev_hi  = 10;

        // 6. rise exactly at cnt_p == TIMEOUT_CYC, then one cycle beyond
        drive_period(10, 10);
        drive_period(10, 90);
        drive_period(10, 10);
        check_eq("p100_lost",   32'(lost), 32'd0);
        check_eq("p100_period", 32'(period), 32'd100);
        drive_period(10, 91);
        drive_period(10, 10);
        drive_period(10, 10);
        rise_edge();
        sig_in = 1'b1;
        repeat (10) @(negedge clki);
        sig_in = 1'b0;
        repeat (20) @(negedge clki);

        check_eq("sb_empty", 32'(sb_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
